// File: rtl/reg_file_pkg.sv
// Shared sizing constants and data type for the 8 x 16 register file.
package reg_file_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/reg_file.sv
// Single-port register file: one write or one registered read per clock,
// with synchronous active-low clear of every entry and of the read register.
module reg_file
    import reg_file_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD_EN,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] Address_Reg,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [DATA_WIDTH-1:0] RD_DATA
);

    data_t r_mem [DEPTH];
    data_t r_rd_data;

    // Write takes priority over read; a write never disturbs RD_DATA.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else if (WR_EN) begin
            r_mem[Address_Reg] <= WR_DATA;
        end else if (RD_EN) begin
            r_rd_data <= r_mem[Address_Reg];
        end
    end

    assign RD_DATA = r_rd_data;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    int          n_tests;
    int          n_fail;

    logic [15:0] model_mem [8];
    logic [15:0] model_rd;

    reg_file u_dut (
        .CLK         (clk),
        .RST         (rst),
        .RD_EN       (rd_en),
        .WR_EN       (wr_en),
        .Address_Reg (addr),
        .WR_DATA     (wr_data),
        .RD_DATA     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare 1 time unit after the edge.
    task automatic step(input string tag, input logic r, input logic we, input logic re,
                        input logic [2:0] a, input logic [15:0] d);
        rst     = r;
        wr_en   = we;
        rd_en   = re;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        if (!r) begin
            foreach (model_mem[i]) model_mem[i] = 16'h0000;
            model_rd = 16'h0000;
        end else if (we) begin
            model_mem[a] = d;
        end else if (re) begin
            model_rd = model_mem[a];
        end
        check(tag, rd_data, model_rd);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        model_rd = 16'h0000;
        foreach (model_mem[i]) model_mem[i] = 16'h0000;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wr_data = 16'h0000;

        step("reset", 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        check("reset_const", rd_data, 16'h0000);
        step("rd0_after_reset", 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            step("rd_all_zero", 1'b1, 1'b0, 1'b1, 3'(i), 16'h0000);
        end

        step("wr_hides_rd", 1'b1, 1'b1, 1'b0, 3'd0, 16'h000F);
        check("wr_hides_rd_const", rd_data, 16'h0000);
        step("rd_back0", 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000);
        check("rd_back0_const", rd_data, 16'h000F);
        step("hold_on_wr", 1'b1, 1'b1, 1'b0, 3'd1, 16'hFFFF);
        check("hold_on_wr_const", rd_data, 16'h000F);
        step("rd_back1", 1'b1, 1'b0, 1'b1, 3'd1, 16'h0000);
        check("rd_back1_const", rd_data, 16'hFFFF);
        step("simul_wr_rd", 1'b1, 1'b1, 1'b1, 3'd2, 16'h1234);
        check("simul_wr_rd_const", rd_data, 16'hFFFF);
        step("rd_back2", 1'b1, 1'b0, 1'b1, 3'd2, 16'h0000);
        check("rd_back2_const", rd_data, 16'h1234);
        step("idle", 1'b1, 1'b0, 1'b0, 3'd5, 16'hBEEF);

        for (int i = 0; i < 8; i++) begin
            step("fill", 1'b1, 1'b1, 1'b0, 3'(i), 16'hA500 + 16'(i));
        end
        for (int i = 0; i < 8; i++) begin
            step("fill_rd", 1'b1, 1'b0, 1'b1, 3'(i), 16'h0000);
        end
        // Reset edge carrying a write and a read: both must be dropped.
        step("mid_reset", 1'b0, 1'b1, 1'b1, 3'd3, 16'h7777);
        check("mid_reset_const", rd_data, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            step("rd_after_mid_reset", 1'b1, 1'b0, 1'b1, 3'(i), 16'h0000);
        end

        for (int n = 0; n < 400; n++) begin
            step("random",
                 ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 0),
                 3'($urandom_range(0, 7)),
                 16'($urandom));
        end
        for (int i = 0; i < 8; i++) begin
            step("final_rd", 1'b1, 1'b0, 1'b1, 3'(i), 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
